// File: rtl/fifo_rd_drain_if.sv
// Read-drain handshake bundle: FIFO pop side (rinc/rempty/rdata) and the valid/ready output stream.
interface fifo_rd_drain_if #(parameter int WIDTH = 8);
   logic             rinc;
   logic             rempty;
   logic [WIDTH-1:0] rdata;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (output rinc, m_valid, m_data, input rempty, rdata, m_ready);
   modport slave  (input rinc, m_valid, m_data, output rempty, rdata, m_ready);
endinterface

// File: rtl/fifo_rd_drain.sv
// Turns the asyn_fifo read port (1-cycle RAM latency) into a full-throughput valid/ready stream.
// Optional build macro FIFO_RD_DRAIN_CNT_EN adds the rd_cnt transfer counter and registered stall flag.
module fifo_rd_drain #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   fifo_rd_drain_if.master bus
`ifdef FIFO_RD_DRAIN_CNT_EN
   ,
   output logic [31:0]   rd_cnt,
   output logic          stall
`endif
);

   logic [WIDTH-1:0] r_mem [0:1];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_occ;
   logic             r_infl;

   logic             w_valid;
   logic             w_xfer;
   logic [1:0]       w_level;
   logic             w_pop;

   // occ+infl never exceeds 2, so a 2-bit sum cannot wrap
   assign w_level = r_occ + {1'b0, r_infl};
   assign w_valid = (r_occ != 2'd0);
   assign w_xfer  = w_valid && bus.m_ready;
   // A slot freed by this cycle's transfer may be refilled at once; this m_ready path is deliberate.
   assign w_pop   = !rst && !bus.rempty &&
                    ((w_level <= 2'd1) || ((w_level == 2'd2) && w_xfer));

   assign bus.rinc    = w_pop;
   assign bus.m_valid = w_valid;
   assign bus.m_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
         r_infl   <= 1'b0;
      end else begin
         r_infl <= w_pop;
         if (r_infl) begin
            r_mem[r_wr_ptr] <= bus.rdata;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_xfer)
            r_rd_ptr <= ~r_rd_ptr;
         case ({r_infl, w_xfer})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

`ifdef FIFO_RD_DRAIN_CNT_EN
   logic [31:0] r_rd_cnt;
   logic        r_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_cnt <= 32'd0;
         r_stall  <= 1'b0;
      end else begin
         if (w_xfer)
            r_rd_cnt <= r_rd_cnt + 32'd1;
         r_stall <= w_valid && !bus.m_ready;
      end
   end

   assign rd_cnt = r_rd_cnt;
   assign stall  = r_stall;
`endif

endmodule
